shift_chaser_param: RTL and testbench
=====================================

Name: shift_chaser_param

Overview:
- Parametrised bidirectional shift/LED-chaser engine, the next generation of the board's 8-bit left/right shift register.
- Adds:
  - generic width
  - built-in step prescaler
  - synchronised direction switch
  - selectable modes: rotate, fill, ping-pong, hold
  - parallel load and enable
- Drives a board LED bank directly from the 50 MHz system clock; no external slow clock.

Parameters:
- WIDTH, 8: number of register/LED bits; minimum 2.
- DIV, 50000: system clocks per shift step; minimum 1. DIV=1 steps every cycle.
- SYNC_STAGES, 2: flip-flop stages on the asynchronous sw input; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sw  in  1  direction switch, asynchronous to clk: 1 = shift left (toward MSB), 0 = shift right.
- mode  in  2  00 rotate, 01 fill, 10 ping-pong, 11 hold.
- en  in  1  1 = prescaler runs; 0 = prescaler and q frozen.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value captured on load.
- q  out  WIDTH  register/LED outputs.
- step  out  1  one-cycle pulse on every clock in which q shifts.
- dir  out  1  current effective direction: 1 = left.

Behaviour:
- Reset values (asynchronous):
  - q = 1 (LSB lit, all other bits 0)
  - prescaler count = 0
  - step = 0
  - dir = 1
  - all sync flops = 1
- Synchroniser: sw passes through SYNC_STAGES flops to give sw_s; 2-3 cycle latency before sw_s is usable.
- Prescaler:
  - cnt runs 0..DIV-1 while en=1.
  - tick is asserted for the single cycle in which cnt==DIV-1; cnt wraps to 0 on that cycle.
  - en=0 holds cnt and suppresses tick.
- Load priority (highest): load=1 → q<=load_val and cnt<=0 on that edge. No shift and no step occur in that cycle, regardless of tick.
- On tick with load=0, by mode:
  - Rotate (00):
    - left: q <= {q[WIDTH-2:0], q[WIDTH-1]}
    - right: q <= {q[0], q[WIDTH-1:1]}
    - dir = sw_s.
  - Fill (01):
    - left: shift in 1 at LSB.
    - right: shift in 1 at MSB.
    - If q is all ones at the tick, q <= 0 instead (restart). dir = sw_s.
  - Ping-pong (10):
    - sw_s is ignored; dir is an internal register.
    - If dir=1 and q[WIDTH-1]=1, set dir<=0 and rotate right in the same tick.
    - If dir=0 and q[0]=1, set dir<=1 and rotate left in the same tick.
    - Otherwise rotate in dir. End LEDs are therefore never held for two steps.
  - Hold (11): q unchanged, step=0; prescaler keeps running.
- Zero recovery: in rotate and ping-pong, q==0 at a tick loads q<=1 (counts as a shift, step=1).
- step is registered: high in the cycle after the edge that changed q by a shift. Never asserted on a load.
- dir output:
  - rotate/fill/hold: sw_s
  - ping-pong: internal register
- Mode change: takes effect at the next tick. Entering ping-pong, the internal dir register is loaded from sw_s.
- Reset mid-operation: immediate return to reset values; the prescaler phase is discarded.

Decomposition:
- Package shift_chaser_pkg holds:
  - mode constants MODE_ROTATE=2'b00, MODE_FILL=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11
  - DIR_LEFT=1'b1, DIR_RIGHT=1'b0
- Sub-module tick_prescaler (params DIV; ports clk, reset, en, clr, tick) provides the shared divider. clr is driven by load.
- Synchroniser stays inline.

Test Plan (WIDTH=8, DIV=4, SYNC_STAGES=2):
1. Reset, then rotate with sw=1, en=1 → q goes 01,02,04,…,80,01, one step every 4 clocks; step pulses 1 cycle each.
2. Rotate with sw=0 from 01 → 80,40,…; toggling sw mid-run reverses direction within 1 tick plus 2 sync cycles.
3. Fill with sw=1 from 00 → 01,03,07,…,FF,00,01; with sw=0 → 80,C0,…,FF,00.
4. Ping-pong from 01 → 02,04,…,80,40,…,01,02; dir flips exactly at 80 and 01; sw toggles have no effect.
5. Hold and en: mode=11 for 20 clocks gives q static and step=0. en=0 freezes cnt; on return to en=1, q resumes after the remaining count.
6. load=1 with load_val=A5 on a tick cycle → q=A5, no step; next shift exactly 4 clocks later. Rotate from q=00 recovers to 01. Asserting reset mid-count returns q=01 asynchronously.

Source files
------------

// File: rtl/shift_chaser_pkg.sv
// Shared constants for the shift/LED chaser: mode encodings, direction values
// and a small helper for sizing the prescaler counter.
package shift_chaser_pkg;

  localparam logic [1:0] MODE_ROTATE   = 2'b00;
  localparam logic [1:0] MODE_FILL     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/shift_chaser_tick_prescaler.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the terminal count
// as a one-cycle tick. clr restarts the phase from zero.
module tick_prescaler
  import shift_chaser_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_chaser_param.sv
// Parametrised bidirectional shift / LED chaser with rotate, fill, ping-pong
// and hold modes, a synchronised direction switch and a built-in prescaler.
module shift_chaser_param
  import shift_chaser_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV         = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             dir
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sw_s;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             step_q;
  logic             step_d;
  logic             pp_dir_q;
  logic             pp_dir_d;

  logic             tick;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] fill_left;
  logic [WIDTH-1:0] fill_right;
  logic             q_zero;
  logic             q_full;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw};
  assign sw_s   = sync_q[SYNC_STAGES-1];

  assign rot_left   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign rot_right  = {q_q[0], q_q[WIDTH-1:1]};
  assign fill_left  = {q_q[WIDTH-2:0], 1'b1};
  assign fill_right = {1'b1, q_q[WIDTH-1:1]};
  assign q_zero     = (q_q == '0);
  assign q_full     = &q_q;

  always_comb begin
    q_d      = q_q;
    step_d   = 1'b0;
    pp_dir_d = pp_dir_q;

    // Outside ping-pong the bounce register shadows the switch, so entering
    // ping-pong starts in the direction the switch last selected.
    if (mode != MODE_PINGPONG) begin
      pp_dir_d = sw_s;
    end

    if (load) begin
      q_d = load_val;
    end else if (tick) begin
      unique case (mode)
        MODE_ROTATE: begin
          step_d = 1'b1;
          if (q_zero) begin
            q_d = ONE;
          end else begin
            q_d = (sw_s == DIR_LEFT) ? rot_left : rot_right;
          end
        end
        MODE_FILL: begin
          step_d = 1'b1;
          if (q_full) begin
            q_d = '0;
          end else begin
            q_d = (sw_s == DIR_LEFT) ? fill_left : fill_right;
          end
        end
        MODE_PINGPONG: begin
          step_d = 1'b1;
          if (q_zero) begin
            q_d = ONE;
          end else if (pp_dir_q == DIR_LEFT && q_q[WIDTH-1]) begin
            // Bounce off the end in the same tick so end LEDs never linger.
            pp_dir_d = DIR_RIGHT;
            q_d      = rot_right;
          end else if (pp_dir_q == DIR_RIGHT && q_q[0]) begin
            pp_dir_d = DIR_LEFT;
            q_d      = rot_left;
          end else begin
            q_d = (pp_dir_q == DIR_LEFT) ? rot_left : rot_right;
          end
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '1;
      q_q      <= ONE;
      step_q   <= 1'b0;
      pp_dir_q <= DIR_LEFT;
    end else begin
      sync_q   <= sync_d;
      q_q      <= q_d;
      step_q   <= step_d;
      pp_dir_q <= pp_dir_d;
    end
  end

  assign q    = q_q;
  assign step = step_q;
  assign dir  = (mode == MODE_PINGPONG) ? pp_dir_q : sw_s;

endmodule

// File: tb/tb_shift_chaser_param.sv
// Directed bench for shift_chaser_param (WIDTH=8, DIV=4, SYNC_STAGES=2):
// a table of per-step expectations plus hand-written hold/enable/load/reset sequences.
module tb_shift_chaser_param;
  import shift_chaser_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic [1:0] mode;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       step;
  logic       dir;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] mode;
    logic       sw;
    logic       do_load;
    logic [7:0] lval;
    logic [7:0] exp_q;
    logic       exp_dir;
    int         exp_gap;
  } vec_t;

  vec_t vecs[$];

  shift_chaser_param #(
    .WIDTH       (8),
    .DIV         (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .sw       (sw),
    .mode     (mode),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .step     (step),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [1:0] m, input logic s, input logic dl,
                              input logic [7:0] lv, input logic [7:0] eq, input logic ed);
    vec_t v;
    v.mode = m; v.sw = s; v.do_load = dl; v.lval = lv;
    v.exp_q = eq; v.exp_dir = ed; v.exp_gap = 4;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the load edge.
  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
    check("load_q", {24'd0, q}, {24'd0, v});
    check("load_step", {31'd0, step}, 32'd0);
  endtask

  // Counts negedges until step is seen high, bounded.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 64);
    if (!step) check("step_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] held;

    rst = 1'b1; sw = 1'b1; mode = MODE_ROTATE; en = 1'b1;
    load = 1'b0; load_val = 8'h00;

    // Rotate left, then right, then reversed mid-run
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h02, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h04, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h08, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h10, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h20, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h40, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h80, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h01, 1);
    add(MODE_ROTATE, 0, 0, 8'h00, 8'h80, 0);
    add(MODE_ROTATE, 0, 0, 8'h00, 8'h40, 0);
    add(MODE_ROTATE, 0, 0, 8'h00, 8'h20, 0);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h40, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h80, 1);
    add(MODE_ROTATE, 1, 0, 8'h00, 8'h01, 1);
    // Fill left from zero, through all ones, restart
    add(MODE_FILL, 1, 1, 8'h00, 8'h01, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h03, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h07, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h0F, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h1F, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h3F, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h7F, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'hFF, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h00, 1);
    add(MODE_FILL, 1, 0, 8'h00, 8'h01, 1);
    // Fill right
    add(MODE_FILL, 0, 1, 8'h00, 8'h80, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hC0, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hE0, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hF0, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hF8, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hFC, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hFE, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'hFF, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'h00, 0);
    add(MODE_FILL, 0, 0, 8'h00, 8'h80, 0);
    // Ping-pong from 01 with the switch toggling (must be ignored)
    add(MODE_PINGPONG, 1, 1, 8'h01, 8'h02, 1);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h04, 1);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h08, 1);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h10, 1);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h20, 1);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h40, 1);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h80, 1);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h40, 0);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h20, 0);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h10, 0);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h08, 0);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h04, 0);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h02, 0);
    add(MODE_PINGPONG, 1, 0, 8'h00, 8'h01, 0);
    add(MODE_PINGPONG, 0, 0, 8'h00, 8'h02, 1);

    repeat (2) @(negedge clk);
    check("reset_q", {24'd0, q}, 32'h01);
    check("reset_step", {31'd0, step}, 32'd0);
    check("reset_dir", {31'd0, dir}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      sw   = vecs[i].sw;
      if (vecs[i].do_load) do_load(vecs[i].lval);
      wait_step(n);
      $display("[TB] vec %0d mode=%0d sw=%0b q=%02h dir=%0b gap=%0d", i, vecs[i].mode, vecs[i].sw, q, dir, n);
      check("vec_gap", n, vecs[i].exp_gap);
      check("vec_q", {24'd0, q}, {24'd0, vecs[i].exp_q});
      check("vec_dir", {31'd0, dir}, {31'd0, vecs[i].exp_dir});
    end

    // Hold: 20 clocks with q static and no step
    sw = 1'b1;
    mode = MODE_HOLD;
    held = q;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_q", {24'd0, q}, {24'd0, held});
      check("hold_step", {31'd0, step}, 32'd0);
    end
    $display("[TB] hold 20 clocks q=%02h", q);

    // Enable freeze: stop at cnt=2, resume needs two more clocks
    mode = MODE_ROTATE;
    do_load(8'h01);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("frozen_step", {31'd0, step}, 32'd0);
    end
    check("frozen_q", {24'd0, q}, 32'h01);
    en = 1'b1;
    wait_step(n);
    $display("[TB] en resume q=%02h gap=%0d", q, n);
    check("resume_gap", n, 2);
    check("resume_q", {24'd0, q}, 32'h02);

    // Load on a tick cycle: no step, phase restarts
    repeat (3) @(negedge clk);
    do_load(8'hA5);
    wait_step(n);
    $display("[TB] after load A5 q=%02h gap=%0d", q, n);
    check("postload_gap", n, 4);
    check("postload_q", {24'd0, q}, 32'h4B);

    // Zero recovery in rotate
    do_load(8'h00);
    wait_step(n);
    $display("[TB] zero recovery q=%02h gap=%0d", q, n);
    check("zero_gap", n, 4);
    check("zero_q", {24'd0, q}, 32'h01);

    // Asynchronous reset mid-count
    repeat (2) @(negedge clk);
    do_load(8'h40);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_q", {24'd0, q}, 32'h01);
    check("async_reset_step", {31'd0, step}, 32'd0);
    check("async_reset_dir", {31'd0, dir}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_step(n);
    $display("[TB] after reset q=%02h gap=%0d", q, n);
    check("reset_gap", n, 4);
    check("reset_first_q", {24'd0, q}, 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
